sm_pattern_sequencer: RTL and testbench

//   Sequences the 1-bit input of a downstream 4-state Moore FSM (input x, output y) from a

---
 rtl/sm_pattern_sequencer_pkg.sv | 12 +
 rtl/sm_pattern_sequencer_if.sv | 22 ++
 rtl/sm_pattern_sequencer_bit_tick_div.sv | 15 +
 rtl/sm_pattern_sequencer.sv | 107 ++++++++++
 tb/tb_sm_pattern_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sm_pattern_sequencer_pkg.sv
// sm_pattern_sequencer_pkg: shared widths and state encoding for the pattern sequencer
package sm_pattern_sequencer_pkg;
    localparam int PAT_W = 16;
    localparam int DIV_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        DRIVE  = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/sm_pattern_sequencer_if.sv
// sm_pattern_sequencer_if: control-side and FSM-side signals of the pattern sequencer
interface sm_pattern_sequencer_if;
    import sm_pattern_sequencer_pkg::*;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [DIV_W-1:0] div;
    logic             x_out;
    logic             fsm_rst_n;
    logic             y_in;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] y_count;
    modport master (
        output start, pattern, len, div, y_in,
        input  x_out, fsm_rst_n, busy, done, y_count
    );
    modport slave (
        input  start, pattern, len, div, y_in,
        output x_out, fsm_rst_n, busy, done, y_count
    );
endinterface

// File: rtl/sm_pattern_sequencer_bit_tick_div.sv
// sm_pattern_sequencer_bit_tick_div: bit-period counter, ticks on the last cycle of each bit
module sm_pattern_sequencer_bit_tick_div
    import sm_pattern_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;
    assign o_tick = !i_clr && (r_cnt == i_div);
    always_ff @(posedge clk)
        r_cnt <= (!reset || i_clr || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/sm_pattern_sequencer.sv
// sm_pattern_sequencer: drives a serial pattern into a Moore FSM and counts sampled y=1 bits
module sm_pattern_sequencer
    import sm_pattern_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    sm_pattern_sequencer_if.slave io_bus
);
    state_t           r_state, w_state_n;
    logic [PAT_W-1:0] r_pat, w_pat_n;
    logic [LEN_W-1:0] r_len, w_len_n, r_idx, w_idx_n, r_cnt, w_cnt_n;
    logic [DIV_W-1:0] r_div, w_div_n;
    logic             r_x, w_x_n, r_frst, w_frst_n, r_busy, w_busy_n, r_done, w_done_n;
    logic             w_tick;
    sm_pattern_sequencer_bit_tick_div u_div (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (r_state != DRIVE),
        .i_div  (r_div),
        .o_tick (w_tick)
    );
    assign io_bus.x_out     = r_x;
    assign io_bus.fsm_rst_n = r_frst;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.y_count   = r_cnt;
    // r_pat shifts right each bit so the next bit to present is always r_pat[1]
    always_comb begin
        w_state_n = r_state;
        w_pat_n   = r_pat;
        w_len_n   = r_len;
        w_div_n   = r_div;
        w_idx_n   = r_idx;
        w_cnt_n   = r_cnt;
        w_x_n     = r_x;
        w_frst_n  = r_frst;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_frst_n = 1'b1;
                w_x_n    = 1'b0;
                if (io_bus.start) begin
                    w_cnt_n = '0;
                    if (io_bus.len != '0) begin
                        w_pat_n   = io_bus.pattern;
                        w_len_n   = io_bus.len;
                        w_div_n   = io_bus.div;
                        w_busy_n  = 1'b1;
                        w_frst_n  = 1'b0;
                        w_state_n = CLEAR;
                    end else
                        w_done_n = 1'b1;
                end
            end
            CLEAR: begin
                w_frst_n  = 1'b1;
                w_x_n     = r_pat[0];
                w_idx_n   = '0;
                w_state_n = DRIVE;
            end
            DRIVE: begin
                if (w_tick) begin
                    w_cnt_n = (io_bus.y_in && r_cnt != r_len) ? r_cnt + 1'b1 : r_cnt;
                    if (r_idx == r_len - 1'b1) begin
                        w_x_n     = 1'b0;
                        w_state_n = FINISH;
                    end else begin
                        w_idx_n = r_idx + 1'b1;
                        w_x_n   = r_pat[1];
                        w_pat_n = r_pat >> 1;
                    end
                end
            end
            FINISH: begin
                w_done_n  = 1'b1;
                w_busy_n  = 1'b0;
                w_state_n = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_div   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_frst  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pat   <= w_pat_n;
            r_len   <= w_len_n;
            r_div   <= w_div_n;
            r_idx   <= w_idx_n;
            r_cnt   <= w_cnt_n;
            r_x     <= w_x_n;
            r_frst  <= w_frst_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end
endmodule

// File: tb/tb_sm_pattern_sequencer.sv
// tb_sm_pattern_sequencer: scoreboard bench for the pattern sequencer with a reference Moore FSM
module tb_sm_pattern_sequencer;
    import sm_pattern_sequencer_pkg::*;
    typedef struct {int cnt; int lat;} exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic use_fsm = 1'b0;
    logic y_tie = 1'b0;
    logic [1:0] fsm_s;
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    bit x_tr[0:127];
    bit f_tr[0:127];
    exp_t sb[$];
    sm_pattern_sequencer_if bus();
    sm_pattern_sequencer dut (.clk(clk), .reset(reset), .io_bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // plant: y=1 after three consecutive x=1 samples, any x=0 returns to S0
    function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic x);
        return x ? ((s == 2'd3) ? 2'd3 : s + 2'd1) : 2'd0;
    endfunction
    always @(posedge clk) fsm_s <= !bus.fsm_rst_n ? 2'd0 : fsm_next(fsm_s, bus.x_out);
    assign bus.y_in = use_fsm ? (fsm_s == 2'd3) : y_tie;
    task automatic do_run(input logic [15:0] pat, input int len, input int dv, input int budget,
                          input int poke, output bit got, output int lat, output bit busy_seen,
                          output int cnt);
        int t0;
        @(negedge clk);
        bus.pattern = pat;
        bus.len = LEN_W'(len);
        bus.div = DIV_W'(dv);
        bus.start = 1'b1;
        t0 = cyc + 1;
        got = 0;
        lat = -1;
        busy_seen = 0;
        cnt = -1;
        for (int k = 0; k < budget && k < 128 && !got; k++) begin
            @(negedge clk);
            bus.start = (k == poke);
            if (k == poke) begin
                bus.pattern = ~pat;
                bus.len = LEN_W'(2);
                bus.div = '0;
            end
            x_tr[k] = bus.x_out;
            f_tr[k] = bus.fsm_rst_n;
            if (bus.busy) busy_seen = 1;
            if (bus.done) begin
                got = 1;
                lat = cyc - t0;
                cnt = int'(bus.y_count);
            end
        end
        bus.start = 1'b0;
    endtask
    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (bus.fsm_rst_n !== 1'b0) $display("FAIL reset_frst_in_reset: got %b want 0", bus.fsm_rst_n); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (bus.x_out !== 1'b0) $display("FAIL reset_x: got %b want 0", bus.x_out); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.y_count !== '0) $display("FAIL reset_ycount: got %0d want 0", bus.y_count); else n_pass++;
        n_total++; if (bus.fsm_rst_n !== 1'b1) $display("FAIL idle_frst: got %b want 1", bus.fsm_rst_n); else n_pass++;
    endtask
    task automatic test_all_ones;
        bit got, bs;
        int lat, cnt, ones, lows;
        exp_t e;
        use_fsm = 1'b0;
        y_tie = 1'b1;
        sb.push_back('{4, 6});
        do_run(16'h000F, 4, 0, 40, -1, got, lat, bs, cnt);
        e = sb.pop_front();
        ones = 0;
        lows = 0;
        for (int k = 0; k <= lat; k++) begin
            ones += int'(x_tr[k]);
            lows += int'(!f_tr[k]);
        end
        n_total++; if (!got) $display("FAIL ones_done: no done within budget"); else n_pass++;
        n_total++; if (lat != e.lat) $display("FAIL ones_latency: got %0d want %0d", lat, e.lat); else n_pass++;
        n_total++; if (cnt != e.cnt) $display("FAIL ones_ycount: got %0d want %0d", cnt, e.cnt); else n_pass++;
        n_total++; if (ones != 4) $display("FAIL ones_x_cycles: got %0d want 4", ones); else n_pass++;
        n_total++; if (lows != 1 || f_tr[0] !== 1'b0) $display("FAIL ones_frst_low: got %0d cycles (first %b) want 1 (0)", lows, f_tr[0]); else n_pass++;
    endtask
    task automatic test_fsm_pattern;
        bit got, bs;
        int lat, cnt, bad, c;
        logic [1:0] s;
        logic [15:0] pat;
        exp_t e;
        pat = 16'b0101;
        use_fsm = 1'b1;
        s = 2'd0;
        c = 0;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++) begin
                if (j == 3 && s == 2'd3) c++;
                s = fsm_next(s, pat[b]);
            end
        sb.push_back('{c, 18});
        do_run(pat, 4, 3, 60, -1, got, lat, bs, cnt);
        e = sb.pop_front();
        bad = 0;
        for (int k = 1; k <= 16; k++) if (x_tr[k] !== pat[(k-1)/4]) bad++;
        n_total++; if (!got) $display("FAIL fsm_done: no done within budget"); else n_pass++;
        n_total++; if (lat != e.lat) $display("FAIL fsm_latency: got %0d want %0d", lat, e.lat); else n_pass++;
        n_total++; if (cnt != e.cnt) $display("FAIL fsm_ycount: got %0d want %0d", cnt, e.cnt); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL fsm_x_hold: got %0d wrong cycles want 0", bad); else n_pass++;
        n_total++; if (x_tr[17] !== 1'b0) $display("FAIL fsm_x_finish: got %b want 0", x_tr[17]); else n_pass++;
        use_fsm = 1'b0;
    endtask
    task automatic test_len_zero;
        bit got, bs;
        int lat, cnt;
        exp_t e;
        y_tie = 1'b1;
        sb.push_back('{0, 0});
        do_run(16'hFFFF, 0, 5, 10, -1, got, lat, bs, cnt);
        e = sb.pop_front();
        n_total++; if (!got) $display("FAIL len0_done: no done within budget"); else n_pass++;
        n_total++; if (lat != e.lat) $display("FAIL len0_latency: got %0d want %0d", lat, e.lat); else n_pass++;
        n_total++; if (cnt != e.cnt) $display("FAIL len0_ycount: got %0d want %0d", cnt, e.cnt); else n_pass++;
        n_total++; if (bs) $display("FAIL len0_busy: got 1 want 0"); else n_pass++;
    endtask
    task automatic test_start_ignored;
        bit got, bs;
        int lat, cnt, ones;
        exp_t e;
        y_tie = 1'b1;
        sb.push_back('{6, 14});
        do_run(16'h003F, 6, 1, 60, 3, got, lat, bs, cnt);
        e = sb.pop_front();
        ones = 0;
        for (int k = 0; k <= lat; k++) ones += int'(x_tr[k]);
        n_total++; if (!got) $display("FAIL ignore_done: no done within budget"); else n_pass++;
        n_total++; if (lat != e.lat) $display("FAIL ignore_latency: got %0d want %0d", lat, e.lat); else n_pass++;
        n_total++; if (cnt != e.cnt) $display("FAIL ignore_ycount: got %0d want %0d", cnt, e.cnt); else n_pass++;
        n_total++; if (ones != 12) $display("FAIL ignore_x_cycles: got %0d want 12", ones); else n_pass++;
    endtask
    task automatic test_reset_mid_run;
        bit got, bs;
        int lat, cnt, dones;
        exp_t e;
        y_tie = 1'b1;
        @(negedge clk);
        bus.pattern = 16'h00FF;
        bus.len = LEN_W'(8);
        bus.div = DIV_W'(1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (bus.busy !== 1'b1 || bus.x_out !== 1'b1) $display("FAIL abort_pre: got busy %b x %b want 1 1", bus.busy, bus.x_out); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (bus.x_out !== 1'b0 || bus.fsm_rst_n !== 1'b0) $display("FAIL abort_x_frst: got %b %b want 0 0", bus.x_out, bus.fsm_rst_n); else n_pass++;
        n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL abort_busy_done: got %b %b want 0 0", bus.busy, bus.done); else n_pass++;
        n_total++; if (bus.y_count !== '0) $display("FAIL abort_ycount: got %0d want 0", bus.y_count); else n_pass++;
        reset = 1'b1;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        n_total++; if (dones != 0) $display("FAIL abort_no_done: got %0d pulses want 0", dones); else n_pass++;
        sb.push_back('{3, 5});
        do_run(16'h0007, 3, 0, 30, -1, got, lat, bs, cnt);
        e = sb.pop_front();
        n_total++; if (!got || lat != e.lat) $display("FAIL post_abort_latency: got %0d want %0d", lat, e.lat); else n_pass++;
        n_total++; if (cnt != e.cnt) $display("FAIL post_abort_ycount: got %0d want %0d", cnt, e.cnt); else n_pass++;
    endtask
    task automatic test_back_to_back;
        int t0, dones;
        exp_t e;
        y_tie = 1'b1;
        sb.push_back('{2, 4});
        sb.push_back('{2, 9});
        @(negedge clk);
        bus.pattern = 16'h0003;
        bus.len = LEN_W'(2);
        bus.div = '0;
        bus.start = 1'b1;
        t0 = cyc + 1;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 5) begin
                n_total++; if (bus.busy !== 1'b1) $display("FAIL b2b_reaccept: got busy %b want 1", bus.busy); else n_pass++;
            end
            if (bus.done) begin
                dones++;
                if (sb.size() == 0) begin
                    n_total++; $display("FAIL b2b_extra_done: got done at %0d want none", cyc - t0);
                end else begin
                    e = sb.pop_front();
                    n_total++; if (cyc - t0 != e.lat) $display("FAIL b2b_done_time: got %0d want %0d", cyc - t0, e.lat); else n_pass++;
                    n_total++; if (int'(bus.y_count) != e.cnt) $display("FAIL b2b_ycount: got %0d want %0d", bus.y_count, e.cnt); else n_pass++;
                end
            end
            if (k == 9) bus.start = 1'b0;
        end
        n_total++; if (dones != 2) $display("FAIL b2b_runs: got %0d want 2", dones); else n_pass++;
        n_total++; if (sb.size() != 0) $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); else n_pass++;
        sb.delete();
    endtask
    initial begin
        bus.start = 1'b0;
        bus.pattern = '0;
        bus.len = '0;
        bus.div = '0;
        test_reset();
        test_all_ones();
        test_fsm_pattern();
        test_len_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
